// File: rtl/myip2_s_axi_burst_mem.sv
// rtl/myip2_s_axi_burst_mem.sv - AXI burst slave over a 64x32 byte-strobed memory, independent read/write FSMs.
// Define MYIP2_WRAP_BURST_EN to accept WRAP bursts; otherwise WRAP is answered with SLVERR.
module myip2_s_axi_burst_mem #(
  parameter int C_S_AXI_ID_WIDTH = 1
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_AWID,
  input  logic [7:0]                  S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic [1:0]                  S_AXI_AWBURST,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [31:0]                 S_AXI_WDATA,
  input  logic [3:0]                  S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [7:0]                  S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_RID,
  output logic [31:0]                 S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY
);

`ifdef MYIP2_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic burst_ok(input logic [1:0] burst, input logic [7:0] len);
    case (burst)
      2'b00, 2'b01: burst_ok = 1'b1;
      2'b10:        burst_ok = WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      default:      burst_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] next_addr(input logic [7:0] addr, input logic [7:0] len,
                                           input logic [1:0] burst);
    logic [7:0] mask;
    mask = ((len + 8'd1) << 2) - 8'd1;
    case (burst)
      2'b01:   next_addr = addr + 8'd4;
      2'b10:   next_addr = (addr & ~mask) | ((addr + 8'd4) & mask);
      default: next_addr = addr;
    endcase
  endfunction

  logic [31:0] mem [64];

  w_state_t                    w_state;
  logic                        aw_ready, w_ready, b_valid;
  logic [C_S_AXI_ID_WIDTH-1:0] b_id;
  logic [1:0]                  b_resp;
  logic [7:0]                  w_addr, w_len, w_cnt;
  logic [1:0]                  w_burst;
  logic                        w_ok;
  logic                        mem_we;

  r_state_t                    r_state;
  logic                        ar_ready, r_valid, r_last;
  logic [C_S_AXI_ID_WIDTH-1:0] r_id;
  logic [1:0]                  r_resp;
  logic [31:0]                 r_data;
  logic [7:0]                  r_addr, r_len, r_cnt;
  logic [1:0]                  r_burst;
  logic                        r_ok;
  logic                        ar_ok;

  assign mem_we = (w_state == W_DATA) && w_ready && S_AXI_WVALID && w_ok;
  assign ar_ok  = burst_ok(S_AXI_ARBURST, S_AXI_ARLEN);

  // Memory is deliberately left out of reset so contents survive ARESET.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (S_AXI_WSTRB[i]) mem[w_addr[7:2]][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_id     <= '0;
      b_resp   <= RESP_OKAY;
      w_addr   <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_burst  <= '0;
      w_ok     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_ready && S_AXI_AWVALID) begin
            b_id     <= S_AXI_AWID;
            w_addr   <= S_AXI_AWADDR;
            w_len    <= S_AXI_AWLEN;
            w_burst  <= S_AXI_AWBURST;
            w_ok     <= burst_ok(S_AXI_AWBURST, S_AXI_AWLEN);
            w_cnt    <= '0;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            w_state  <= W_DATA;
          end else begin
            aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_ready && S_AXI_WVALID) begin
            w_addr <= next_addr(w_addr, w_len, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_resp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RDATA is loaded on the AR handshake so the first beat is valid one cycle later.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_id     <= '0;
      r_resp   <= RESP_OKAY;
      r_data   <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_burst  <= '0;
      r_ok     <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_ready && S_AXI_ARVALID) begin
            r_id     <= S_AXI_ARID;
            r_ok     <= ar_ok;
            r_len    <= S_AXI_ARLEN;
            r_burst  <= S_AXI_ARBURST;
            r_addr   <= next_addr(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST);
            r_cnt    <= '0;
            r_valid  <= 1'b1;
            r_last   <= (S_AXI_ARLEN == 8'd0);
            r_resp   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            r_data   <= ar_ok ? mem[S_AXI_ARADDR[7:2]] : 32'h0;
            ar_ready <= 1'b0;
            r_state  <= R_DATA;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_valid && S_AXI_RREADY) begin
            if (r_last) begin
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              ar_ready <= 1'b1;
              r_state  <= R_IDLE;
            end else begin
              r_data <= r_ok ? mem[r_addr[7:2]] : 32'h0;
              r_addr <= next_addr(r_addr, r_len, r_burst);
              r_cnt  <= r_cnt + 8'd1;
              r_last <= (r_cnt + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BID     = b_id;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RID     = r_id;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = r_resp;
  assign S_AXI_RLAST   = r_last;
  assign S_AXI_RVALID  = r_valid;

endmodule

// File: tb/tb_myip2_s_axi_burst_mem.sv
// tb/tb_myip2_s_axi_burst_mem.sv - scoreboard bench for myip2_s_axi_burst_mem with a behavioural memory model.
module tb_myip2_s_axi_burst_mem;
  localparam int IDW = 1;
`ifdef MYIP2_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic           S_AXI_ACLK = 1'b0;
  logic           S_AXI_ARESET;
  logic [IDW-1:0] S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
  logic [7:0]     S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_ARADDR, S_AXI_ARLEN;
  logic [1:0]     S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic           S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]    S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]     S_AXI_WSTRB;
  logic           S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic           S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  myip2_s_axi_burst_mem #(.C_S_AXI_ID_WIDTH(IDW)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARID(S_AXI_ARID),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RID(S_AXI_RID),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } r_exp_t;
  typedef struct { logic [1:0] resp; logic [IDW-1:0] id; } b_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  r_exp_t      re;
  b_exp_t      be;
  logic [31:0] model [64];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  int          checks = 0;
  int          failures = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=no_handshake required=handshake", name);
  endtask

  function automatic bit legal(input logic [1:0] b, input int len);
    if (b == 2'b00 || b == 2'b01) return 1'b1;
    if (b == 2'b10) return WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b0;
  endfunction

  // Wrap is expressed as an offset inside an aligned window of (len+1) words.
  function automatic int nxt(input int addr, input int len, input logic [1:0] b);
    int size, base;
    if (b == 2'b01) return (addr + 4) % 256;
    if (b == 2'b10) begin
      size = (len + 1) * 4;
      base = (addr / size) * size;
      return base + (addr - base + 4) % size;
    end
    return addr;
  endfunction

  always @(negedge S_AXI_ACLK) begin
    if (S_AXI_ARESET !== 1'b0) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (!(S_AXI_RVALID === 1'b1 && S_AXI_RDATA === hold_data && S_AXI_RLAST === hold_last)) begin
          failures++;
          $display("FAIL r_hold actual=v%b d%h l%b required=v1 d%h l%b",
                   S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, hold_data, hold_last);
        end
      end
      hold_pend = S_AXI_RVALID && !S_AXI_RREADY;
      hold_data = S_AXI_RDATA;
      hold_last = S_AXI_RLAST;
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) tmo("unexpected_b");
        else begin
          be = bq.pop_front();
          chk("bresp", 32'(S_AXI_BRESP), 32'(be.resp));
          chk("bid", 32'(S_AXI_BID), 32'(be.id));
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) tmo("unexpected_r");
        else begin
          re = rq.pop_front();
          chk("rdata", S_AXI_RDATA, re.data);
          chk("rresp", 32'(S_AXI_RRESP), 32'(re.resp));
          chk("rlast", 32'(S_AXI_RLAST), 32'(re.last));
          chk("rid", 32'(S_AXI_RID), 32'(re.id));
        end
      end
    end
  end

  task automatic wait_aw(output bit ok);
    int t = 0;
    do begin @(negedge S_AXI_ACLK); t++; end while (!S_AXI_AWREADY && t < 200);
    ok = S_AXI_AWREADY;
    if (!ok) tmo("aw");
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, output bit ok);
    int t = 0;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    do begin @(negedge S_AXI_ACLK); t++; end while (!S_AXI_WREADY && t < 200);
    ok = S_AXI_WREADY;
    if (!ok) tmo("w");
    @(posedge S_AXI_ACLK); #1;
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input int addr, input int len,
                          input logic [1:0] b, input bit rnd);
    bit ok = legal(b, len);
    bit hs;
    int a = addr;
    int t = 0;
    bq.push_back('{ok ? 2'b00 : 2'b10, id});
    if (ok) begin
      for (int i = 0; i <= len; i++) begin
        for (int k = 0; k < 4; k++) if (ws[i][k]) model[a / 4][8*k +: 8] = wd[i][8*k +: 8];
        a = nxt(a, len, b);
      end
    end
    S_AXI_AWID = id; S_AXI_AWADDR = 8'(addr); S_AXI_AWLEN = 8'(len); S_AXI_AWBURST = b;
    S_AXI_AWVALID = 1'b1;
    wait_aw(hs);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    if (!hs) return;
    for (int i = 0; i <= len; i++) begin
      if (rnd) repeat ($urandom % 3) begin @(posedge S_AXI_ACLK); #1; end
      send_beat(wd[i], ws[i], hs);
      if (!hs) return;
    end
    forever begin
      S_AXI_BREADY = rnd ? 1'($urandom % 2) : 1'b1;
      @(negedge S_AXI_ACLK);
      if (S_AXI_BVALID && S_AXI_BREADY) break;
      t++;
      if (t > 200) begin tmo("b"); S_AXI_BREADY = 1'b0; return; end
      @(posedge S_AXI_ACLK); #1;
    end
    @(posedge S_AXI_ACLK); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge S_AXI_ACLK);
    chk("awready_after_b", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge S_AXI_ACLK); #1;
  endtask

  // mode 0: RREADY held high; 1: random RREADY; 2: RREADY low for 3 cycles mid-burst
  task automatic do_read(input logic [IDW-1:0] id, input int addr, input int len,
                         input logic [1:0] b, input int mode);
    bit ok = legal(b, len);
    int a = addr;
    int t = 0;
    int c = 0;
    for (int i = 0; i <= len; i++) begin
      rq.push_back('{ok ? model[a / 4] : 32'h0, ok ? 2'b00 : 2'b10, (i == len), id});
      a = nxt(a, len, b);
    end
    S_AXI_ARID = id; S_AXI_ARADDR = 8'(addr); S_AXI_ARLEN = 8'(len); S_AXI_ARBURST = b;
    S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    do begin @(negedge S_AXI_ACLK); t++; end while (!S_AXI_ARREADY && t < 200);
    if (!S_AXI_ARREADY) begin tmo("ar"); S_AXI_ARVALID = 1'b0; return; end
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    forever begin
      case (mode)
        0:       S_AXI_RREADY = 1'b1;
        1:       S_AXI_RREADY = ($urandom % 4) != 0;
        default: S_AXI_RREADY = !(c >= 1 && c <= 3);
      endcase
      @(negedge S_AXI_ACLK);
      if (c == 0) chk("first_rvalid", 32'(S_AXI_RVALID), 32'd1);
      if (S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST) break;
      if (c > 600) begin tmo("r_last"); S_AXI_RREADY = 1'b0; return; end
      @(posedge S_AXI_ACLK); #1;
      c++;
    end
    if (mode == 0) chk("read_beat_per_cycle", 32'(c), 32'(len));
    @(posedge S_AXI_ACLK); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge S_AXI_ACLK);
    chk("arready_after_r", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge S_AXI_ACLK); #1;
  endtask

  task automatic pick(output logic [1:0] b, output int len, output int addr);
    int r = $urandom % 8;
    int wl [5] = '{1, 3, 7, 15, 2};
    if (r == 0) b = 2'b00;
    else if (r <= 3) b = 2'b01;
    else if (r <= 6) b = 2'b10;
    else b = 2'b11;
    len = (b == 2'b10) ? wl[$urandom % 5] : int'($urandom % 16);
    addr = $urandom % 256;
  endtask

  initial begin
    logic [1:0] b;
    int len, addr;
    bit hs;
    S_AXI_ARESET = 1'b1;
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge S_AXI_ACLK);
    #1;
    @(negedge S_AXI_ACLK);
    chk("rst_ready", {28'd0, S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID}, 32'd0);
    chk("rst_rvalid_rlast", {30'd0, S_AXI_RVALID, S_AXI_RLAST}, 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_ids_resps", 32'({S_AXI_BID, S_AXI_RID, S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARESET = 1'b0;
    @(posedge S_AXI_ACLK); #1;
    @(negedge S_AXI_ACLK);
    chk("awready_after_rst", 32'(S_AXI_AWREADY), 32'd1);
    chk("arready_after_rst", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge S_AXI_ACLK); #1;

    // Fill the whole memory so every later read has a defined expectation.
    for (int i = 0; i < 64; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(0, 0, 63, 2'b01, 1'b0);
    do_read(1, 0, 63, 2'b01, 1);

    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    wd[0] = 32'hFFFF_FFFF; wd[15] = 32'h00AB_CDEF;
    do_write(0, 8'h00, 15, 2'b01, 1'b0);
    do_read(1, 8'h00, 15, 2'b01, 0);

    wd[0] = 32'h1122_3344; ws[0] = 4'b1111;
    do_write(1, 8'h10, 0, 2'b01, 1'b0);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(0, 8'h10, 0, 2'b01, 1'b1);
    do_read(0, 8'h10, 0, 2'b01, 1);

    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(0, 8'h00, 3, 2'b01, 1'b0);
    do_read(1, 8'h08, 3, 2'b10, 0);

    wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(1, 8'h40, 1, 2'b11, 1'b1);
    do_read(0, 8'h40, 1, 2'b01, 0);
    do_read(1, 8'h40, 1, 2'b11, 0);

    do_read(0, 8'h00, 7, 2'b01, 2);

    // Reset in the middle of a write: two beats land, the burst is dropped.
    S_AXI_AWID = 0; S_AXI_AWADDR = 8'h20; S_AXI_AWLEN = 8'd3; S_AXI_AWBURST = 2'b01;
    S_AXI_AWVALID = 1'b1;
    wait_aw(hs);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wd[i] = $urandom;
      model[8 + i] = wd[i];
      send_beat(wd[i], 4'hF, hs);
    end
    S_AXI_ARESET = 1'b1;
    @(posedge S_AXI_ACLK); #1;
    @(negedge S_AXI_ACLK);
    chk("midrst_ready_valid", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 32'd0);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARESET = 1'b0;
    @(negedge S_AXI_ACLK);
    chk("midrst_bvalid_a", 32'(S_AXI_BVALID), 32'd0);
    @(posedge S_AXI_ACLK); #1;
    @(negedge S_AXI_ACLK);
    chk("midrst_awready", 32'(S_AXI_AWREADY), 32'd1);
    chk("midrst_bvalid_b", 32'(S_AXI_BVALID), 32'd0);
    @(posedge S_AXI_ACLK); #1;
    do_read(0, 8'h20, 3, 2'b01, 1);

    for (int n = 0; n < 20; n++) begin
      pick(b, len, addr);
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(IDW'($urandom), addr, len, b, 1'b1);
      do_read(IDW'($urandom), addr, len, b, int'($urandom % 2));
      pick(b, len, addr);
      do_read(IDW'($urandom), addr, len, b, (len >= 3) ? 2 : 1);
    end

    repeat (5) @(posedge S_AXI_ACLK);
    #1;
    chk("b_queue_drained", 32'(bq.size()), 32'd0);
    chk("r_queue_drained", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/myip2_s_axi_burst_mem.md
MYIP2_S_AXI_BURST_MEM -- requirements
Module: myip2_s_axi_burst_mem

Interface
REQ-001 C_S_AXI_ID_WIDTH, default 1, width of AWID/BID/ARID/RID.
REQ-002 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-003 S_AXI_ARESET  in  1  reset; synchronous, active-high.
REQ-004 S_AXI_AWID  in  C_S_AXI_ID_WIDTH  write ID.
REQ-005 S_AXI_AWADDR  in  8  write start byte address.
REQ-006 S_AXI_AWLEN  in  8  write beats minus one.
REQ-007 S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-008 S_AXI_AWVALID  in  1  AW valid.
REQ-009 S_AXI_AWREADY  out  1  AW ready.
REQ-010 S_AXI_WDATA  in  32  write data.
REQ-011 S_AXI_WSTRB  in  4  byte enables; bit i writes byte lane i.
REQ-012 S_AXI_WVALID  in  1  W valid.
REQ-013 S_AXI_WREADY  out  1  W ready.
REQ-014 S_AXI_BID  out  C_S_AXI_ID_WIDTH  echoes AWID.
REQ-015 S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
REQ-016 S_AXI_BVALID  out  1  B valid.
REQ-017 S_AXI_BREADY  in  1  B ready.
REQ-018 S_AXI_ARID  in  C_S_AXI_ID_WIDTH  read ID.
REQ-019 S_AXI_ARADDR  in  8  read start byte address.
REQ-020 S_AXI_ARLEN  in  8  read beats minus one.
REQ-021 S_AXI_ARBURST  in  2  same encoding as AWBURST.
REQ-022 S_AXI_ARVALID  in  1  AR valid.
REQ-023 S_AXI_ARREADY  out  1  AR ready.
REQ-024 S_AXI_RID  out  C_S_AXI_ID_WIDTH  echoes ARID.
REQ-025 S_AXI_RDATA  out  32  read data.
REQ-026 S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
REQ-027 S_AXI_RLAST  out  1  final read beat.
REQ-028 S_AXI_RVALID  out  1  R valid.
REQ-029 S_AXI_RREADY  in  1  R ready.

Function
REQ-030 SHALL hold 64x32 memory; word index = addr[7:2], addr[1:0] ignored; beat size fixed 4 bytes; write beat count from AWLEN only (no WLAST port).
REQ-031 Write FSM W_IDLE(AWREADY=1) -> AW handshake latches ID/addr/len/burst -> W_DATA(WREADY=1, one beat per W handshake) -> after beat len+1 -> W_RESP(BVALID=1) -> B handshake -> W_IDLE; AWREADY re-asserts cycle after B handshake.
REQ-032 Read FSM R_IDLE(ARREADY=1) -> AR handshake -> R_DATA; first RVALID exactly 1 cycle after AR handshake; RDATA registered; RLAST=1 on beat len+1; last R handshake -> R_IDLE, ARREADY next cycle.
REQ-033 SHALL sustain one beat per cycle when VALID/READY held high; RVALID/RDATA/RLAST stable while RREADY=0.
REQ-034 Next address: FIXED unchanged; INCR +4 modulo 256; WRAP: mask=(len+1)*4-1, next=(addr&~mask)|((addr+4)&mask).
REQ-035 Illegal burst (AxBURST=11, or WRAP with len not 1/3/7/15): full beat count still exchanged; writes not stored, BRESP=10; reads RDATA=0, RRESP=10 every beat, RLAST on final beat.
REQ-036 Write and read FSMs independent; same word written and read same cycle -> read returns old data.

Reset
REQ-037 While ARESET=1 at a rising edge: FSMs -> IDLE; AWREADY/ARREADY/WREADY/BVALID/RVALID/RLAST=0; BID/RID/BRESP/RRESP/RDATA=0; AWREADY/ARREADY=1 first cycle after release; memory not cleared; in-flight bursts dropped without response.

Configuration
REQ-038 MYIP2_WRAP_BURST_EN defined: WRAP per REQ-034. Undefined: every WRAP burst handled as illegal per REQ-035.

Verification
REQ-039 INCR write len=15 @0x00, words 0xFFFFFFFF..0x00ABCDEF, then INCR read len=15 @0x00 -> identical 16 words, all RRESP=00, RLAST only beat 16, BRESP=00.
REQ-040 (EN defined) WRAP read len=3 @0x08 after writes mem[0..3]=A,B,C,D -> RDATA C,D,A,B.
REQ-041 Write 0x11223344 @0x10 WSTRB=1111, then 0xAABBCCDD WSTRB=0101 -> read 0x11BB33DD.
REQ-042 AWBURST=11 len=1 -> 2 W beats accepted, BRESP=10, memory unchanged; ARBURST=11 len=1 -> 2 beats RDATA=0 RRESP=10.
REQ-043 RREADY=0 for 3 cycles mid-burst -> RDATA held; ARESET mid-write -> no BVALID, AWREADY=1 cycle after release.
